// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, one-entry stall buffer, IF/ID register.
// Define FETCH_PERF_EN to add the fetch_cnt_o / bubble_cnt_o performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        ID_valid_o,
  output logic [31:0] ID_instr_o,
  output logic [31:0] ID_pc_o,
  output logic [31:0] ID_pc4_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  // state | meaning
  // IDLE  | in reset; leaves on the first cycle out of reset
  // REQ   | presenting pc_q to imem
  // WAIT  | request accepted, waiting for its response
  // KILL  | response still owed for a redirected fetch; discard it
  // HOLD  | response buffered while ID is stalled
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_KILL,
    S_HOLD
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;

  logic        w_deliver_wait;
  logic        w_deliver_hold;
  logic        w_deliver;
  logic [31:0] w_deliver_instr;
  logic [31:0] w_redir_pc;
  logic        w_unused_redir_lsbs;

  assign w_redir_pc          = {redirect_pc_i[31:2], 2'b00};
  assign w_unused_redir_lsbs = ^redirect_pc_i[1:0];

  assign w_deliver_wait  = (r_state == S_WAIT) && imem_rvalid_i && !redirect_i && !flush_i && !stall_i;
  assign w_deliver_hold  = (r_state == S_HOLD) && !redirect_i && !flush_i && !stall_i;
  assign w_deliver       = w_deliver_wait || w_deliver_hold;
  assign w_deliver_instr = (r_state == S_HOLD) ? r_hold : imem_rdata_i;

  // A redirect in REQ suppresses the request so the old pc_q is never issued.
  assign imem_req_o  = (r_state == S_REQ) && !redirect_i;
  assign imem_addr_o = r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (redirect_i) r_pc <= w_redir_pc;
          else if (imem_ready_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (redirect_i) begin
            r_pc    <= w_redir_pc;
            r_state <= imem_rvalid_i ? S_REQ : S_KILL;
          end else if (imem_rvalid_i) begin
            if (flush_i) begin
              r_state <= S_REQ;
            end else if (stall_i) begin
              r_hold  <= imem_rdata_i;
              r_state <= S_HOLD;
            end else begin
              r_pc    <= r_pc + 32'd4;
              r_state <= S_REQ;
            end
          end
        end
        S_KILL: begin
          if (redirect_i) r_pc <= w_redir_pc;
          if (imem_rvalid_i) r_state <= S_REQ;
        end
        S_HOLD: begin
          // A flush kills the buffered word too; pc_q is unchanged so it is refetched.
          if (redirect_i) begin
            r_pc    <= w_redir_pc;
            r_state <= S_REQ;
          end else if (flush_i) begin
            r_state <= S_REQ;
          end else if (!stall_i) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= '0;
    end else if (flush_i) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end else if (stall_i) begin
      r_id_valid <= r_id_valid;
    end else if (w_deliver) begin
      r_id_valid <= 1'b1;
      r_id_instr <= w_deliver_instr;
      r_id_pc    <= r_pc;
    end else begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end
  end

  assign ID_valid_o = r_id_valid;
  assign ID_instr_o = r_id_instr;
  assign ID_pc_o    = r_id_pc;
  assign ID_pc4_o   = r_id_pc + 32'd4;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_deliver) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (!w_deliver && !stall_i) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o  = r_fetch_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected requests and IF/ID loads,
// monitors pop and compare; a second instance covers RESET_PC wrap-around.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_ready_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        ID_valid_o;
  logic [31:0] ID_instr_o;
  logic [31:0] ID_pc_o;
  logic [31:0] ID_pc4_o;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] bubble_cnt_o;
  logic [31:0] w2_fetch_cnt;
  logic [31:0] w2_bubble_cnt;
`endif

  logic        w2_zero = 1'b0;
  logic        w2_one = 1'b1;
  logic [31:0] w2_zero32 = '0;
  logic        w2_rvalid = 1'b0;
  logic        w2_req;
  logic [31:0] w2_addr;
  logic        w2_valid;
  logic [31:0] w2_instr;
  logic [31:0] w2_pc;
  logic [31:0] w2_pc4;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .ID_valid_o(ID_valid_o), .ID_instr_o(ID_instr_o), .ID_pc_o(ID_pc_o), .ID_pc4_o(ID_pc4_o)
`ifdef FETCH_PERF_EN
    , .fetch_cnt_o(fetch_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall_i(w2_zero), .flush_i(w2_zero),
    .redirect_i(w2_zero), .redirect_pc_i(w2_zero32),
    .imem_req_o(w2_req), .imem_addr_o(w2_addr), .imem_ready_i(w2_one),
    .imem_rvalid_i(w2_rvalid), .imem_rdata_i(w2_zero32),
    .ID_valid_o(w2_valid), .ID_instr_o(w2_instr), .ID_pc_o(w2_pc), .ID_pc4_o(w2_pc4)
`ifdef FETCH_PERF_EN
    , .fetch_cnt_o(w2_fetch_cnt), .bubble_cnt_o(w2_bubble_cnt)
`endif
  );

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } id_t;

  id_t         id_q[$];
  logic [31:0] addr_q[$];
  id_t         mon_e;
  logic        stall_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_id(input logic [31:0] pc, input logic [31:0] instr);
    id_q.push_back({pc, instr});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Memory model: responds after 'lat' idle cycles with rdata = addr ^ 32'h5A00_0000.
  int          lat = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_dly = 0;

  always @(negedge clk) begin
    if (rst_n && imem_req_o && imem_ready_i) begin
      pend      = 1'b1;
      pend_addr = imem_addr_o;
      pend_dly  = lat;
    end
  end

  always @(posedge clk) begin
    stall_q <= stall_i;
    #1;
    if (pend && pend_dly == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = pend_addr ^ 32'h5A00_0000;
      pend          = 1'b0;
    end else begin
      imem_rvalid_i = 1'b0;
      if (pend) pend_dly--;
    end
  end

  always @(negedge clk) begin
    if (rst_n && imem_req_o && imem_ready_i) begin
      if (addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL req_addr: got unexpected request %h expected none", imem_addr_o);
      end else begin
        chk("req_addr", imem_addr_o, addr_q.pop_front());
      end
    end
    if (rst_n && ID_valid_o && !stall_q) begin
      if (id_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL id_load: got unexpected pc %h instr %h expected none", ID_pc_o, ID_instr_o);
      end else begin
        mon_e = id_q.pop_front();
        chk("id_pc", ID_pc_o, mon_e.pc);
        chk("id_instr", ID_instr_o, mon_e.instr);
        chk("id_pc4", ID_pc4_o, mon_e.pc + 32'd4);
      end
    end
  end

  logic        pend2 = 1'b0;
  logic [31:0] wrap_addr[2];
  int          wrap_n = 0;
  logic        wrap_seen = 1'b0;
  logic [31:0] wrap_pc4 = 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (rst_n && w2_req) begin
      if (wrap_n < 2) wrap_addr[wrap_n] = w2_addr;
      wrap_n++;
      pend2 = 1'b1;
    end
    if (rst_n && w2_valid && !wrap_seen) begin
      wrap_seen = 1'b1;
      wrap_pc4  = w2_pc4;
    end
  end

  always @(posedge clk) begin
    #1;
    w2_rvalid = pend2;
    pend2     = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wrap_addr[0] = 32'hDEAD_BEEF;
    wrap_addr[1] = 32'hDEAD_BEEF;
    imem_ready_i = 1'b1;
    tick(2);
    chk("rst_valid", {31'd0, ID_valid_o}, 32'd0);
    chk("rst_instr", ID_instr_o, 32'h0000_0013);
    chk("rst_pc", ID_pc_o, 32'd0);
    chk("rst_pc4", ID_pc4_o, 32'd4);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);

    // sequential fetch, zero-wait memory
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    addr_q.push_back(32'h8);
    push_id(32'h0, 32'h5A00_0000);
    push_id(32'h4, 32'h5A00_0004);
    push_id(32'h8, 32'h5A00_0008);
    rst_n = 1'b1;
    tick(3);
    chk("seq_valid0", {31'd0, ID_valid_o}, 32'd1);
    tick(1);
    chk("seq_bubble_valid", {31'd0, ID_valid_o}, 32'd0);
    chk("seq_bubble_instr", ID_instr_o, 32'h0000_0013);
    tick(3);
    chk("seq_pc8", ID_pc_o, 32'h8);
    imem_ready_i = 1'b0;
    tick(1);

    // stall held three cycles while the response lands
    addr_q.push_back(32'hC);
    push_id(32'hC, 32'h5A00_000C);
    imem_ready_i = 1'b1;
    tick(1);
    stall_i = 1'b1;
    tick(1);
    chk("hold_req0", {31'd0, imem_req_o}, 32'd0);
    chk("hold_valid", {31'd0, ID_valid_o}, 32'd0);
    tick(2);
    chk("hold_pc", ID_pc_o, 32'h8);
    chk("hold_instr", ID_instr_o, 32'h0000_0013);
    chk("hold_req2", {31'd0, imem_req_o}, 32'd0);
    stall_i = 1'b0;
    imem_ready_i = 1'b0;
    tick(1);
    chk("hold_out_valid", {31'd0, ID_valid_o}, 32'd1);
    chk("hold_next_addr", imem_addr_o, 32'h10);
    tick(1);

    // redirect while waiting on a slow response
    addr_q.push_back(32'h10);
    lat = 2;
    imem_ready_i = 1'b1;
    tick(1);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0101;
    tick(1);
    redirect_i = 1'b0;
    lat = 0;
    chk("kill_req0", {31'd0, imem_req_o}, 32'd0);
    tick(1);
    chk("kill_req1", {31'd0, imem_req_o}, 32'd0);
    addr_q.push_back(32'h100);
    push_id(32'h100, 32'h5A00_0100);
    tick(1);
    chk("redir_req", {31'd0, imem_req_o}, 32'd1);
    chk("redir_addr", imem_addr_o, 32'h100);
    chk("stale_dropped", {31'd0, ID_valid_o}, 32'd0);
    tick(1);
    imem_ready_i = 1'b0;
    tick(1);

    // flush coincident with the response: discard and refetch
    addr_q.push_back(32'h104);
    addr_q.push_back(32'h104);
    push_id(32'h104, 32'h5A00_0104);
    imem_ready_i = 1'b1;
    tick(1);
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
    chk("flush_valid", {31'd0, ID_valid_o}, 32'd0);
    chk("flush_instr", ID_instr_o, 32'h0000_0013);
    chk("flush_pc_held", ID_pc_o, 32'h100);
    chk("flush_refetch", imem_addr_o, 32'h104);
    tick(1);
    imem_ready_i = 1'b0;
    tick(1);
    chk("refetch_pc4", ID_pc4_o, 32'h108);

    // reset mid-transaction; the late response must be ignored
    addr_q.push_back(32'h108);
    imem_ready_i = 1'b1;
    lat = 1;
    tick(1);
    rst_n = 1'b0;
    lat = 0;
    tick(1);
    chk("mid_rst_valid", {31'd0, ID_valid_o}, 32'd0);
    chk("mid_rst_pc", ID_pc_o, 32'd0);
    chk("mid_rst_pc4", ID_pc4_o, 32'd4);
    chk("mid_rst_req", {31'd0, imem_req_o}, 32'd0);
    addr_q.push_back(32'h0);
    push_id(32'h0, 32'h5A00_0000);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_valid", {31'd0, ID_valid_o}, 32'd0);
    chk("post_rst_addr", imem_addr_o, 32'h0);
    tick(1);
    imem_ready_i = 1'b0;
    tick(1);
    chk("post_rst_fetch", {31'd0, ID_valid_o}, 32'd1);

`ifdef FETCH_PERF_EN
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    stall_i = 1'b1;
    imem_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      addr_q.push_back(32'(k * 4));
      push_id(32'(k * 4), 32'h5A00_0000 | 32'(k * 4));
    end
    tick(1);
    stall_i = 1'b0;
    tick(19);
    imem_ready_i = 1'b0;
    tick(1);
    chk("perf_fetch", fetch_cnt_o, 32'd10);
    chk("perf_bubble", bubble_cnt_o, 32'd10);
    rst_n = 1'b0;
    tick(1);
    chk("perf_fetch_rst", fetch_cnt_o, 32'd0);
    chk("perf_bubble_rst", bubble_cnt_o, 32'd0);
    rst_n = 1'b1;
`endif

    tick(3);
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
    chk("id_q_drained", 32'(id_q.size()), 32'd0);
    chk("wrap_addr0", wrap_addr[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", wrap_addr[1], 32'h0000_0000);
    chk("wrap_pc4", wrap_pc4, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the fetch address loaded at reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the instruction word presented to ID on reset, flush and bubble.
REQ-003 Ports SHALL be as follows, in this order:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- stall_i  in  1  hold the IF/ID register (load-use stall from hazard control)
- flush_i  in  1  kill the IF/ID contents (taken branch/jump)
- redirect_i  in  1  load a new fetch target
- redirect_pc_i  in  32  new fetch target
- imem_req_o  out  1  instruction memory request
- imem_addr_o  out  32  request address
- imem_ready_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid
- imem_rdata_i  in  32  response instruction word
- ID_valid_o  out  1  IF/ID holds a live instruction
- ID_instr_o  out  32  IF/ID instruction
- ID_pc_o  out  32  IF/ID PC
- ID_pc4_o  out  32  ID_pc_o + 4

Function
REQ-004 The block SHALL implement the FSM states IDLE, REQ, WAIT, KILL and HOLD, with at most one memory request outstanding.
REQ-005 IDLE SHALL be entered only on reset and SHALL go to REQ on the first cycle with rst_n high.
REQ-006 In REQ, imem_req_o SHALL equal !redirect_i and imem_addr_o SHALL equal pc_q; a request with imem_ready_i high SHALL move the FSM to WAIT.
REQ-007 In WAIT, a response (imem_rvalid_i) with stall_i, flush_i and redirect_i all low SHALL load IF/ID with {rdata, pc_q, valid=1}, advance pc_q by 4 and move the FSM to REQ.
REQ-008 In WAIT, a response with stall_i high and flush_i and redirect_i low SHALL be captured into a one-entry hold buffer, move the FSM to HOLD and leave pc_q unchanged.
REQ-009 In HOLD, the first cycle with stall_i low SHALL transfer the buffer into IF/ID, advance pc_q by 4 and move the FSM to REQ.
REQ-010 redirect_i SHALL have top priority in every state except IDLE: pc_q SHALL load {redirect_pc_i[31:2],2'b00}, any hold buffer SHALL be dropped, and the FSM SHALL go to KILL if a request is outstanding without a response this cycle, otherwise to REQ.
REQ-011 KILL SHALL discard the next response and then go to REQ, and a further redirect_i while in KILL SHALL update pc_q and remain in KILL.
REQ-012 flush_i SHALL clear IF/ID on the next edge (valid=0, instr=NOP_INSTR, PC held) and SHALL take priority over stall_i.
REQ-013 A response arriving in the same cycle as flush_i without redirect_i SHALL be discarded without advancing pc_q, so the same PC is refetched.
REQ-014 With stall_i high and flush_i low, IF/ID SHALL hold all its fields unchanged.
REQ-015 With stall_i low and no instruction delivered, IF/ID SHALL load a bubble (valid=0, instr=NOP_INSTR).
REQ-016 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 SHALL give 0, with no error.
REQ-017 Best-case throughput SHALL be one instruction every 2 cycles with a zero-wait memory (REQ then WAIT).

Reset
REQ-018 While rst_n is low at a clock edge, the block SHALL set FSM=IDLE, pc_q=RESET_PC, imem_req_o=0, ID_valid_o=0, ID_instr_o=NOP_INSTR, ID_pc_o=0 and ID_pc4_o=4, and SHALL clear the hold buffer.
REQ-019 Reset asserted mid-transaction SHALL abandon the outstanding request, and a response arriving after reset SHALL be ignored because IDLE and REQ ignore imem_rvalid_i.

Configuration
REQ-020 With macro FETCH_PERF_EN defined, the block SHALL add outputs fetch_cnt_o[31:0] and bubble_cnt_o[31:0], both reset to 0 and wrapping.
- fetch_cnt_o increments on each edge at which IF/ID loads valid=1.
- bubble_cnt_o increments on each edge at which IF/ID loads valid=0 with stall_i low.
REQ-021 Without FETCH_PERF_EN, the counters and ports SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-022 Reset release with imem_ready_i=1 and 1-cycle rvalid -> addresses 0x0, 0x4, 0x8 are fetched, ID_pc_o sequence is 0, 4, 8, and ID_valid_o alternates with bubbles.
REQ-023 stall_i held 3 cycles while a response arrives -> FSM enters HOLD, ID fields stay frozen, the buffered instr appears one cycle after stall_i falls, and no extra request is issued.
REQ-024 redirect_i with redirect_pc_i=0x100 asserted in WAIT before rvalid -> FSM enters KILL, the stale response is dropped, and the next imem_addr_o is 0x100.
REQ-025 flush_i and imem_rvalid_i in the same cycle with redirect_i low -> ID_valid_o=0, ID_instr_o=0x00000013, and the same PC is re-requested.
REQ-026 RESET_PC=32'hFFFF_FFFC -> the second fetch address is 0x0000_0000.
REQ-027 With FETCH_PERF_EN, 10 delivered instructions and 10 bubbles -> fetch_cnt_o=10 and bubble_cnt_o=10, and reset returns both to 0.
